spmv_network_drain: RTL and testbench

- Arbitrates the PARALLELISM output lanes of the SpMV reduction network onto one result stream.
- Each cycle a round-robin arbiter grants one valid lane. The granted beat enters a single-row accumulator, which merges consecutive beats with equal row id.
- Completed rows leave through a registered valid/ready output.
- A flush request drains the last partial row at the end of a matrix.

---
 rtl/spmv_network_drain_if.sv | 30 +++
 rtl/spmv_network_drain.sv | 178 +++++++++++++++++
 tb/tb_spmv_network_drain.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_network_drain_if.sv
// Signal bundle between the SpMV reduction-network lanes, the drain stage and
// the downstream result consumer.
interface spmv_network_drain_if #(
    parameter int PARALLELISM = 4,
    parameter int ID_WIDTH    = 16,
    parameter int VAL_WIDTH   = 32
);
    logic [PARALLELISM-1:0]           in_valid;
    logic [PARALLELISM-1:0]           in_ready;
    logic [PARALLELISM*ID_WIDTH-1:0]  in_id;
    logic [PARALLELISM*VAL_WIDTH-1:0] in_val;
    logic                             flush;
    logic                             out_valid;
    logic                             out_ready;
    logic [ID_WIDTH-1:0]              out_id;
    logic [VAL_WIDTH-1:0]             out_val;
    logic                             flush_done;
    logic                             busy;

    // master is the lane/consumer environment, slave is the drain itself
    modport master (
        output in_valid, in_id, in_val, flush, out_ready,
        input  in_ready, out_valid, out_id, out_val, flush_done, busy
    );

    modport slave (
        input  in_valid, in_id, in_val, flush, out_ready,
        output in_ready, out_valid, out_id, out_val, flush_done, busy
    );
endinterface

// File: rtl/spmv_network_drain.sv
// Round-robin drain of the SpMV reduction-network lanes into a single-row
// accumulator that emits one completed (row id, sum) per row on a registered port.
module spmv_network_drain #(
    parameter int PARALLELISM = 4,
    parameter int ID_WIDTH    = 16,
    parameter int VAL_WIDTH   = 32
) (
    input logic                clk,
    input logic                rst,
    spmv_network_drain_if.slave bus
);
    localparam int PW = (PARALLELISM > 1) ? $clog2(PARALLELISM) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          ptr_next;

    logic                   acc_valid;
    logic [ID_WIDTH-1:0]    acc_id;
    logic [VAL_WIDTH-1:0]   acc_val;
    logic                   out_valid;
    logic [ID_WIDTH-1:0]    out_id;
    logic [VAL_WIDTH-1:0]   out_val;
    logic                   flush_done;

    logic [ID_WIDTH-1:0]    lane_id  [PARALLELISM];
    logic [VAL_WIDTH-1:0]   lane_val [PARALLELISM];

    logic                   cand_found;
    logic [PW-1:0]          cand_idx;
    logic [ID_WIDTH-1:0]    cand_id;
    logic [VAL_WIDTH-1:0]   cand_val;
    logic                   same_id;
    logic                   out_free;
    logic                   can_accept;
    logic                   grant;
    logic                   load_beat;
    logic                   load_flush;
    logic                   done_next;
    logic [PARALLELISM-1:0] in_ready;

    for (genvar i = 0; i < PARALLELISM; i++) begin : g_unpack
        assign lane_id[i]  = bus.in_id[i*ID_WIDTH +: ID_WIDTH];
        assign lane_val[i] = bus.in_val[i*VAL_WIDTH +: VAL_WIDTH];
    end

    function automatic logic [PW-1:0] lane_at(input logic [PW-1:0] base, input int offset);
        int l;
        l = int'(base) + offset;
        if (l >= PARALLELISM) begin
            l = l - PARALLELISM;
        end
        return PW'(l);
    endfunction

    // First valid lane at or after ptr, wrapping around the lane ring
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int k = 0; k < PARALLELISM; k++) begin
            if (!cand_found && bus.in_valid[lane_at(ptr, k)]) begin
                cand_found = 1'b1;
                cand_idx   = lane_at(ptr, k);
            end
        end
    end

    assign cand_id    = lane_id[cand_idx];
    assign cand_val   = lane_val[cand_idx];
    assign same_id    = (cand_id == acc_id);
    assign out_free   = !out_valid || bus.out_ready;
    assign can_accept = !acc_valid || same_id || out_free;
    assign ptr_next   = (cand_idx == PW'(PARALLELISM - 1)) ? '0 : cand_idx + PW'(1);
    assign load_beat  = grant && acc_valid && !same_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = bus.flush ? FLUSH : ACCUM;
                end
            end
            ACCUM: begin
                if (bus.flush) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (done_next) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grants stop while draining, so the flushed row cannot be extended behind it
    always_comb begin
        grant      = 1'b0;
        load_flush = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                grant     = cand_found && can_accept && !rst;
                done_next = bus.flush && !grant;
            end
            ACCUM: begin
                grant = cand_found && can_accept && !rst;
            end
            FLUSH: begin
                load_flush = acc_valid && out_free;
                done_next  = !acc_valid || out_free;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready = '0;
        if (grant) begin
            in_ready[cand_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            acc_valid  <= 1'b0;
            acc_id     <= '0;
            acc_val    <= '0;
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_val    <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= done_next;
            if (grant) begin
                ptr <= ptr_next;
                if (!acc_valid || !same_id) begin
                    acc_valid <= 1'b1;
                    acc_id    <= cand_id;
                    acc_val   <= cand_val;
                end else begin
                    acc_val <= acc_val + cand_val;
                end
            end else if (load_flush) begin
                acc_valid <= 1'b0;
            end
            // A reload wins over a handshake so back-to-back rows keep out_valid high
            if (load_beat || load_flush) begin
                out_valid <= 1'b1;
                out_id    <= acc_id;
                out_val   <= acc_val;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_id     = out_id;
    assign bus.out_val    = out_val;
    assign bus.flush_done = flush_done;
    assign bus.busy       = (state != IDLE) || acc_valid || out_valid;
endmodule

// File: tb/tb_spmv_network_drain.sv
// Bench for spmv_network_drain: directed scenarios with literal row checks plus a
// randomized run compared every cycle against a transaction-level model.
module tb_spmv_network_drain;
    localparam int P  = 4;
    localparam int IW = 16;
    localparam int VW = 32;

    logic clk;
    logic rst;

    spmv_network_drain_if #(.PARALLELISM(P), .ID_WIDTH(IW), .VAL_WIDTH(VW)) bus ();

    spmv_network_drain #(.PARALLELISM(P), .ID_WIDTH(IW), .VAL_WIDTH(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int doneCount = 0;

    logic          laneV   [P];
    logic [IW-1:0] laneId  [P];
    logic [VW-1:0] laneVal [P];

    logic [IW+VW-1:0] rows[$];
    int               grantLog[$];

    // Model: mode 0 = idle, 1 = accumulating, 2 = draining for a flush
    int            mMode      = 0;
    int            mPtr       = 0;
    bit            mAccValid  = 0;
    logic [IW-1:0] mAccId     = '0;
    logic [VW-1:0] mAccVal    = '0;
    bit            mOutValid  = 0;
    logic [IW-1:0] mOutId     = '0;
    logic [VW-1:0] mOutVal    = '0;
    bit            mDone      = 0;
    int            mLastGrant = -1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] laneIdOf(input int l);
        return bus.in_id[l*IW +: IW];
    endfunction

    function automatic logic [VW-1:0] laneValOf(input int l);
        return bus.in_val[l*VW +: VW];
    endfunction

    function automatic int modelGrant();
        int  c;
        bit  outFree;
        if (rst || mMode == 2) return -1;
        c = -1;
        for (int k = 0; k < P; k++) begin
            if (c < 0 && bus.in_valid[(mPtr + k) % P]) c = (mPtr + k) % P;
        end
        if (c < 0) return -1;
        outFree = !mOutValid || bus.out_ready;
        if (mAccValid && laneIdOf(c) != mAccId && !outFree) return -1;
        return c;
    endfunction

    always @(posedge clk) begin : modelStep
        int            g;
        bit            outFree;
        bit            handshake;
        bit            loadOut;
        logic [IW-1:0] oId;
        logic [VW-1:0] oVal;
        if (rst) begin
            mMode = 0; mPtr = 0; mAccValid = 0; mAccId = '0; mAccVal = '0;
            mOutValid = 0; mOutId = '0; mOutVal = '0; mDone = 0; mLastGrant = -1;
        end else begin
            g         = modelGrant();
            outFree   = !mOutValid || bus.out_ready;
            handshake = mOutValid && bus.out_ready;
            loadOut   = 0;
            oId       = mAccId;
            oVal      = mAccVal;
            mDone     = 0;
            if (g >= 0) begin
                if (!mAccValid) begin
                    mAccId  = laneIdOf(g);
                    mAccVal = laneValOf(g);
                end else if (laneIdOf(g) == mAccId) begin
                    mAccVal = mAccVal + laneValOf(g);
                end else begin
                    loadOut = 1;
                    mAccId  = laneIdOf(g);
                    mAccVal = laneValOf(g);
                end
                mAccValid = 1;
                mPtr      = (g + 1) % P;
            end
            case (mMode)
                0: begin
                    if (bus.flush && g < 0) mDone = 1;
                    else if (g >= 0) mMode = bus.flush ? 2 : 1;
                end
                1: if (bus.flush) mMode = 2;
                default: begin
                    if (mAccValid && outFree) begin
                        loadOut = 1; mAccValid = 0; mDone = 1; mMode = 0;
                    end else if (!mAccValid) begin
                        mDone = 1; mMode = 0;
                    end
                end
            endcase
            if (loadOut) begin
                mOutValid = 1; mOutId = oId; mOutVal = oVal;
            end else if (handshake) begin
                mOutValid = 0;
            end
            mLastGrant = g;
        end
    end

    // Cycle-by-cycle comparison, plus logs of rows and grants for the directed checks
    always @(negedge clk) begin : compare
        logic [P-1:0] expR;
        int           g;
        expR = '0;
        g = modelGrant();
        if (g >= 0) expR[g] = 1'b1;
        checkOutput("in_ready", 64'(bus.in_ready), 64'(expR));
        checkOutput("out_valid", 64'(bus.out_valid), 64'(mOutValid));
        if (mOutValid) begin
            checkOutput("out_id", 64'(bus.out_id), 64'(mOutId));
            checkOutput("out_val", 64'(bus.out_val), 64'(mOutVal));
        end
        checkOutput("flush_done", 64'(bus.flush_done), 64'(mDone));
        checkOutput("busy", 64'(bus.busy), 64'(mMode != 0 || mAccValid || mOutValid));
        if (bus.flush_done) doneCount++;
        if (!rst && bus.out_valid && bus.out_ready) rows.push_back({bus.out_id, bus.out_val});
        if (!rst) begin
            for (int i = 0; i < P; i++) if (bus.in_ready[i]) grantLog.push_back(i);
        end
    end

    task automatic drive();
        for (int i = 0; i < P; i++) begin
            bus.in_valid[i]         = laneV[i];
            bus.in_id[i*IW +: IW]   = laneId[i];
            bus.in_val[i*VW +: VW]  = laneVal[i];
        end
    endtask

    task automatic applyStimulus();
        drive();
        @(posedge clk);
        #1;
        if (mLastGrant >= 0) laneV[mLastGrant] = 1'b0;
        bus.flush = 1'b0;
        drive();
    endtask

    task automatic sendBeat(input int lane, input logic [IW-1:0] id, input logic [VW-1:0] val);
        int n;
        n = 0;
        laneV[lane] = 1'b1; laneId[lane] = id; laneVal[lane] = val;
        while (laneV[lane] && n < 100) begin
            applyStimulus();
            n++;
        end
        if (laneV[lane]) begin
            tests++; fails++;
            $display("[TB] FAIL sendBeat: lane %0d id %0h not accepted within 100 cycles", lane, id);
            laneV[lane] = 1'b0;
        end
    endtask

    task automatic waitLanes();
        int n;
        n = 0;
        while ((laneV[0] || laneV[1] || laneV[2] || laneV[3]) && n < 200) begin
            applyStimulus();
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("[TB] FAIL waitLanes: lanes still pending after 200 cycles");
            for (int i = 0; i < P; i++) laneV[i] = 1'b0;
        end
    endtask

    task automatic pulseFlush();
        bus.flush = 1'b1;
        applyStimulus();
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((mMode != 0 || mAccValid || mOutValid) && n < 500) begin
            applyStimulus();
            n++;
        end
        if (n >= 500) begin
            tests++; fails++;
            $display("[TB] FAIL waitIdle: model not idle after 500 cycles");
        end
        applyStimulus();
        applyStimulus();
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
    endtask

    initial begin
        int            curId;
        logic [IW-1:0] rid;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < P; i++) begin
            laneV[i] = 1'b0; laneId[i] = '0; laneVal[i] = '0;
        end
        drive();
        resetDut();
        @(negedge clk);
        checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset out_id", 64'(bus.out_id), 64'd0);
        checkOutput("reset out_val", 64'(bus.out_val), 64'd0);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);

        // Single lane, merge then new id, then flush
        rows.delete(); doneCount = 0;
        sendBeat(0, 16'd7, 32'd10);
        sendBeat(0, 16'd7, 32'd5);
        sendBeat(0, 16'd8, 32'd1);
        pulseFlush();
        waitIdle();
        @(negedge clk);
        checkOutput("t1 row count", 64'(rows.size()), 64'd2);
        checkOutput("t1 row0", 64'(rows[0]), 64'({16'd7, 32'd15}));
        checkOutput("t1 row1", 64'(rows[1]), 64'({16'd8, 32'd1}));
        checkOutput("t1 flush_done pulses", 64'(doneCount), 64'd1);
        checkOutput("t1 busy", 64'(bus.busy), 64'd0);

        // Four lanes with the same row id, round-robin from lane 0
        resetDut();
        rows.delete(); grantLog.delete();
        for (int i = 0; i < P; i++) begin
            laneV[i] = 1'b1; laneId[i] = 16'd2; laneVal[i] = 32'(i + 1);
        end
        waitLanes();
        pulseFlush();
        waitIdle();
        checkOutput("t2 grant count", 64'(grantLog.size()), 64'd4);
        for (int k = 0; k < 4; k++) checkOutput("t2 grant order", 64'(grantLog[k]), 64'(k));
        checkOutput("t2 row count", 64'(rows.size()), 64'd1);
        checkOutput("t2 row0", 64'(rows[0]), 64'({16'd2, 32'd10}));

        // Backpressure: third row cannot enter until the output drains
        rows.delete();
        bus.out_ready = 1'b0;
        sendBeat(0, 16'd1, 32'd11);
        sendBeat(0, 16'd2, 32'd22);
        laneV[0] = 1'b1; laneId[0] = 16'd3; laneVal[0] = 32'd33;
        drive();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("t3 stalled in_ready", 64'(bus.in_ready), 64'd0);
            checkOutput("t3 held out_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("t3 held out_id", 64'(bus.out_id), 64'd1);
            checkOutput("t3 held out_val", 64'(bus.out_val), 64'd11);
            applyStimulus();
        end
        bus.out_ready = 1'b1;
        waitLanes();
        pulseFlush();
        waitIdle();
        checkOutput("t3 row count", 64'(rows.size()), 64'd3);
        checkOutput("t3 row0", 64'(rows[0]), 64'({16'd1, 32'd11}));
        checkOutput("t3 row1", 64'(rows[1]), 64'({16'd2, 32'd22}));
        checkOutput("t3 row2", 64'(rows[2]), 64'({16'd3, 32'd33}));

        // Sum wraps modulo 2^32
        rows.delete();
        sendBeat(1, 16'd5, 32'hFFFF_FFFF);
        sendBeat(1, 16'd5, 32'd2);
        pulseFlush();
        waitIdle();
        checkOutput("t4 row count", 64'(rows.size()), 64'd1);
        checkOutput("t4 wrap row", 64'(rows[0]), 64'({16'd5, 32'd1}));

        // Flush in idle, then flush together with a same-id beat
        rows.delete();
        pulseFlush();
        @(negedge clk);
        checkOutput("t5 idle flush_done", 64'(bus.flush_done), 64'd1);
        checkOutput("t5 idle out_valid", 64'(bus.out_valid), 64'd0);
        applyStimulus();
        @(negedge clk);
        checkOutput("t5 flush_done one cycle", 64'(bus.flush_done), 64'd0);
        sendBeat(0, 16'd6, 32'd4);
        laneV[0] = 1'b1; laneId[0] = 16'd6; laneVal[0] = 32'd3;
        pulseFlush();
        waitIdle();
        checkOutput("t5 row count", 64'(rows.size()), 64'd1);
        checkOutput("t5 flush with beat", 64'(rows[0]), 64'({16'd6, 32'd7}));

        // Reset mid-row discards the partial row and the arbiter pointer
        sendBeat(0, 16'd4, 32'd9);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6 out_valid after reset", 64'(bus.out_valid), 64'd0);
        checkOutput("t6 busy after reset", 64'(bus.busy), 64'd0);
        rows.delete(); grantLog.delete();
        laneV[0] = 1'b1; laneId[0] = 16'd9; laneVal[0] = 32'd1;
        laneV[1] = 1'b1; laneId[1] = 16'd9; laneVal[1] = 32'd2;
        waitLanes();
        pulseFlush();
        waitIdle();
        checkOutput("t6 first grant lane", 64'(grantLog[0]), 64'd0);
        checkOutput("t6 row count", 64'(rows.size()), 64'd1);
        checkOutput("t6 clean row", 64'(rows[0]), 64'({16'd9, 32'd3}));

        // Randomized traffic with backpressure, flushes and occasional resets
        curId = 100;
        for (int c = 0; c < 3000; c++) begin
            bus.out_ready = ($urandom_range(9) < 7);
            for (int i = 0; i < P; i++) begin
                if (!laneV[i] && $urandom_range(2) == 0) begin
                    if ($urandom_range(9) >= 6) curId++;
                    rid = IW'(curId);
                    laneV[i] = 1'b1; laneId[i] = rid; laneVal[i] = $urandom;
                end
            end
            bus.flush = ($urandom_range(59) == 0);
            rst = ($urandom_range(799) == 0);
            applyStimulus();
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        waitLanes();
        pulseFlush();
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
